// File: rtl/pid_pkg.sv
// Shared widths, types and saturation helper for the PID datapath stages.
package pid_pkg;

  localparam int ERR_W   = 11;
  localparam int DIFF_W  = 8;
  localparam int COEFF_W = 6;
  localparam int DTERM_W = DIFF_W + COEFF_W + 1;

  typedef logic signed [ERR_W-1:0]   err_t;
  typedef logic signed [DIFF_W-1:0]  diff_t;
  typedef logic signed [DTERM_W-1:0] dterm_t;

  // Clamp a signed value into the range representable by a signed 'width'-bit field.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int unsigned width);
    logic signed [31:0] maxV;
    logic signed [31:0] minV;
    maxV = (32'sd1 <<< (width - 1)) - 32'sd1;
    minV = -(32'sd1 <<< (width - 1));
    if (value > maxV) begin
      sat_signed = maxV;
    end else if (value < minV) begin
      sat_signed = minV;
    end else begin
      sat_signed = value;
    end
  endfunction

endpackage

// File: rtl/sat_diff.sv
// Combinational a - b at one bit of headroom, saturated to OUT_W signed with clip flags.
module sat_diff #(
  parameter int IN_W  = pid_pkg::ERR_W,
  parameter int OUT_W = pid_pkg::DIFF_W
) (
  input  logic signed [IN_W-1:0]  a_i,
  input  logic signed [IN_W-1:0]  b_i,
  output logic signed [OUT_W-1:0] sat_diff_o,
  output logic                    sat_hi_o,
  output logic                    sat_lo_o
);
  import pid_pkg::*;

  logic signed [IN_W:0] diff;
  logic signed [31:0]   diffExt;
  logic signed [31:0]   satVal;

  assign diff    = {a_i[IN_W-1], a_i} - {b_i[IN_W-1], b_i};
  assign diffExt = 32'(diff);
  assign satVal  = sat_signed(diffExt, OUT_W);

  // The clamp changed the value exactly when clipping happened; the sign says which way.
  assign sat_diff_o = satVal[OUT_W-1:0];
  assign sat_hi_o   = (satVal != diffExt) && !diffExt[31];
  assign sat_lo_o   = (satVal != diffExt) && diffExt[31];

endmodule

// File: rtl/d_term_hist.sv
// Derivative term: sat(err_sat - err_sat[n-DEPTH]) * d_coeff, registered with a strobe.
// Define D_TERM_PRIME_EN to suppress output until DEPTH real samples are in the history.
module d_term_hist #(
  parameter int ERR_W   = pid_pkg::ERR_W,
  parameter int DIFF_W  = pid_pkg::DIFF_W,
  parameter int COEFF_W = pid_pkg::COEFF_W,
  parameter int DEPTH   = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic signed [ERR_W-1:0]         err_sat,
  input  logic                            err_vld,
  input  logic        [COEFF_W-1:0]       d_coeff,
  input  logic                            clr,
  output logic signed [DIFF_W+COEFF_W:0]  D_term,
  output logic                            d_vld,
  output logic                            sat_hi,
  output logic                            sat_lo
);
  import pid_pkg::*;

  localparam int PROD_W = DIFF_W + COEFF_W + 1;
  localparam int FILL_W = $clog2(DEPTH + 1);

  logic signed [ERR_W-1:0]  hist_q [DEPTH];
  logic signed [ERR_W-1:0]  hist_d [DEPTH];
  logic        [FILL_W-1:0] fill_q, fill_d;
  logic signed [PROD_W-1:0] dterm_q, dterm_d;
  logic                     vld_q, vld_d;
  logic                     satHi_q, satHi_d;
  logic                     satLo_q, satLo_d;

  logic signed [DIFF_W-1:0] satDiff;
  logic                     diffHi;
  logic                     diffLo;
  logic signed [COEFF_W:0]  coeffS;
  logic signed [PROD_W-1:0] diffExt;
  logic signed [PROD_W-1:0] coeffExt;
  logic signed [PROD_W-1:0] product;
  logic                     primed;

  sat_diff #(
    .IN_W  (ERR_W),
    .OUT_W (DIFF_W)
  ) u_sat_diff (
    .a_i        (err_sat),
    .b_i        (hist_q[DEPTH-1]),
    .sat_diff_o (satDiff),
    .sat_hi_o   (diffHi),
    .sat_lo_o   (diffLo)
  );

  // Product width is exactly DIFF_W + COEFF_W + 1, so nothing is lost here.
  assign coeffS   = {1'b0, d_coeff};
  assign diffExt  = PROD_W'(satDiff);
  assign coeffExt = PROD_W'(coeffS);
  assign product  = diffExt * coeffExt;

`ifdef D_TERM_PRIME_EN
  assign primed = (fill_q == FILL_W'(DEPTH));
`else
  assign primed = 1'b1;
`endif

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    dterm_d = dterm_q;
    satHi_d = satHi_q;
    satLo_d = satLo_q;
    vld_d   = 1'b0;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_d[i] = '0;
      end
      fill_d  = '0;
      dterm_d = '0;
      satHi_d = 1'b0;
      satLo_d = 1'b0;
    end else if (err_vld) begin
      hist_d[0] = err_sat;
      for (int i = 1; i < DEPTH; i++) begin
        hist_d[i] = hist_q[i-1];
      end
      if (fill_q != FILL_W'(DEPTH)) begin
        fill_d = fill_q + FILL_W'(1);
      end
      if (primed) begin
        dterm_d = product;
        satHi_d = diffHi;
        satLo_d = diffLo;
        vld_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_q[i] <= '0;
      end
      fill_q  <= '0;
      dterm_q <= '0;
      vld_q   <= 1'b0;
      satHi_q <= 1'b0;
      satLo_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_q[i] <= hist_d[i];
      end
      fill_q  <= fill_d;
      dterm_q <= dterm_d;
      vld_q   <= vld_d;
      satHi_q <= satHi_d;
      satLo_q <= satLo_d;
    end
  end

  assign D_term = dterm_q;
  assign d_vld  = vld_q;
  assign sat_hi = satHi_q;
  assign sat_lo = satLo_q;

endmodule

// File: tb/tb_d_term_hist.sv
// Self-checking bench for d_term_hist at default widths, DEPTH=2.
module tb_d_term_hist;
  import pid_pkg::*;

  localparam int DEPTH = 2;

  logic               clk = 1'b0;
  logic               rst;
  err_t               err_sat;
  logic               err_vld;
  logic [COEFF_W-1:0] d_coeff;
  logic               clr;
  dterm_t             D_term;
  logic               d_vld;
  logic               sat_hi;
  logic               sat_lo;

  int tests = 0;
  int fails = 0;

  // Reference state: sample history newest-first, plus the expected registered outputs.
  int               modelHist[$];
  int               modelFill;
  logic [DTERM_W-1:0] expD;
  logic             expVld;
  logic             expHi;
  logic             expLo;

  d_term_hist #(
    .ERR_W   (ERR_W),
    .DIFF_W  (DIFF_W),
    .COEFF_W (COEFF_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .err_sat (err_sat),
    .err_vld (err_vld),
    .d_coeff (d_coeff),
    .clr     (clr),
    .D_term  (D_term),
    .d_vld   (d_vld),
    .sat_hi  (sat_hi),
    .sat_lo  (sat_lo)
  );

  always #5 clk = ~clk;

  task automatic modelClear();
    modelHist = {};
    for (int i = 0; i < DEPTH; i++) modelHist.push_back(0);
    modelFill = 0;
    expD   = '0;
    expVld = 1'b0;
    expHi  = 1'b0;
    expLo  = 1'b0;
  endtask

  // Drives one cycle of inputs, advances the reference model, and returns #1 after the edge.
  task automatic applyStimulus(input logic vld, input logic [ERR_W-1:0] err,
                               input logic [COEFF_W-1:0] coeff, input logic c);
    int  sErr;
    int  diff;
    int  sd;
    bit  primed;
    err_vld = vld;
    err_sat = err;
    d_coeff = coeff;
    clr     = c;
    if (c) begin
      modelClear();
    end else if (vld) begin
      sErr = int'(err);
      if (err[ERR_W-1]) sErr -= (1 << ERR_W);
      diff = sErr - modelHist[DEPTH-1];
`ifdef D_TERM_PRIME_EN
      primed = (modelFill >= DEPTH);
`else
      primed = 1'b1;
`endif
      if (primed) begin
        expHi = 1'b0;
        expLo = 1'b0;
        sd    = diff;
        if (diff > 127) begin
          sd = 127;
          expHi = 1'b1;
        end else if (diff < -128) begin
          sd = -128;
          expLo = 1'b1;
        end
        expD   = DTERM_W'(sd * int'(coeff));
        expVld = 1'b1;
      end else begin
        expVld = 1'b0;
      end
      modelHist.push_front(sErr);
      void'(modelHist.pop_back());
      if (modelFill < DEPTH) modelFill++;
    end else begin
      expVld = 1'b0;
    end
    @(posedge clk);
    #1;
    err_vld = 1'b0;
    clr     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    err_vld = 1'b0;
    err_sat = '0;
    d_coeff = 6'h38;
    clr = 1'b0;
    modelClear();
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if ({D_term, d_vld, sat_hi, sat_lo} !== {15'h0000, 3'b000}) begin
      fails++;
      $display("[TB] FAIL reset: got D_term=%h vld=%b hi=%b lo=%b, want 0000 0 0 0",
               D_term, d_vld, sat_hi, sat_lo);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [ERR_W-1:0] errs[3];
    logic [17:0]      consts[3];
    errs   = '{11'h030, 11'h0A0, 11'h700};
    consts = '{{15'h0A80, 3'b100}, {15'h1BC8, 3'b110}, {15'h6400, 3'b101}};
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, errs[k], 6'h38, 1'b0);
`ifndef D_TERM_PRIME_EN
      tests++;
      if ({D_term, d_vld, sat_hi, sat_lo} !== consts[k]) begin
        fails++;
        $display("[TB] FAIL directed_const[%0d]: got %h/%b%b%b, want %h/%b", k,
                 D_term, d_vld, sat_hi, sat_lo, consts[k][17:3], consts[k][2:0]);
      end
`endif
      applyStimulus(1'b0, 11'h3FF, 6'h01, 1'b0);
      tests++;
      if ({D_term, d_vld, sat_hi, sat_lo} !== {expD, expVld, expHi, expLo}) begin
        fails++;
        $display("[TB] FAIL directed_hold[%0d]: got %h/%b%b%b, want %h/%b%b%b", k,
                 D_term, d_vld, sat_hi, sat_lo, expD, expVld, expHi, expLo);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(k < 3, 11'h080, 6'h38, 1'b0);
      tests++;
      if ({D_term, d_vld, sat_hi, sat_lo} !== {expD, expVld, expHi, expLo}) begin
        fails++;
        $display("[TB] FAIL back_to_back[%0d]: got %h/%b%b%b, want %h/%b%b%b", k,
                 D_term, d_vld, sat_hi, sat_lo, expD, expVld, expHi, expLo);
      end
    end
  endtask

  task automatic test_clr();
    applyStimulus(1'b1, 11'h050, 6'h38, 1'b1);
    tests++;
    if ({D_term, d_vld, sat_hi, sat_lo} !== {15'h0000, 3'b000}) begin
      fails++;
      $display("[TB] FAIL clr_flush: got %h/%b%b%b, want 0000/000",
               D_term, d_vld, sat_hi, sat_lo);
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, ERR_W'($urandom), 6'h38, 1'b0);
      tests++;
      if ({D_term, d_vld, sat_hi, sat_lo} !== {expD, expVld, expHi, expLo}) begin
        fails++;
        $display("[TB] FAIL clr_refill[%0d]: got %h/%b%b%b, want %h/%b%b%b", k,
                 D_term, d_vld, sat_hi, sat_lo, expD, expVld, expHi, expLo);
      end
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(1'b1, 11'h0C0, 6'h3F, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    modelClear();
    tests++;
    if ({D_term, d_vld, sat_hi, sat_lo} !== {15'h0000, 3'b000}) begin
      fails++;
      $display("[TB] FAIL async_reset: got %h/%b%b%b, want 0000/000",
               D_term, d_vld, sat_hi, sat_lo);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [ERR_W-1:0] e;
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 3))
        0:       e = 11'h3FF - ERR_W'($urandom_range(0, 7));
        1:       e = 11'h400 + ERR_W'($urandom_range(0, 7));
        default: e = ERR_W'($urandom);
      endcase
      applyStimulus($urandom_range(0, 3) != 0, e, COEFF_W'($urandom),
                    $urandom_range(0, 24) == 0);
      tests++;
      if ({D_term, d_vld, sat_hi, sat_lo} !== {expD, expVld, expHi, expLo}) begin
        fails++;
        $display("[TB] FAIL random[%0d]: got %h/%b%b%b, want %h/%b%b%b", k,
                 D_term, d_vld, sat_hi, sat_lo, expD, expVld, expHi, expLo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_clr();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
